// File: rtl/apb_rr_master_arb.sv
// Round-robin arbiter sharing one APB master port between NumReq requesters.
// Only one transfer is in flight at a time; the response returns to the requester that was granted.
module apb_rr_master_arb #(
    parameter int NumReq    = 4,
    parameter int AddrWidth = 32,
    parameter int DataWidth = 32
) (
    input  logic                          pclk_i,
    input  logic                          preset_i,
    input  logic [NumReq-1:0]             req_valid_i,
    output logic [NumReq-1:0]             req_ready_o,
    input  logic [NumReq*AddrWidth-1:0]   req_addr_i,
    input  logic [NumReq-1:0]             req_write_i,
    input  logic [NumReq*DataWidth-1:0]   req_wdata_i,
    output logic [NumReq-1:0]             rsp_valid_o,
    output logic [DataWidth-1:0]          rsp_rdata_o,
    output logic                          rsp_err_o,
    output logic [AddrWidth-1:0]          paddr_o,
    output logic                          pwrite_o,
    output logic [DataWidth-1:0]          pwdata_o,
    output logic                          psel_o,
    output logic                          penable_o,
    input  logic [DataWidth-1:0]          prdata_i,
    input  logic                          pready_i,
    input  logic                          pslverr_i
);
    localparam int IdxWidth = (NumReq > 1) ? $clog2(NumReq) : 1;

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;
    state_t state, state_nxt;

    logic [AddrWidth-1:0] addr_arr  [NumReq];
    logic [DataWidth-1:0] wdata_arr [NumReq];

    for (genvar k = 0; k < NumReq; k++) begin : g_unpack
        assign addr_arr[k]  = req_addr_i[k*AddrWidth +: AddrWidth];
        assign wdata_arr[k] = req_wdata_i[k*DataWidth +: DataWidth];
    end

    logic [IdxWidth-1:0]   ptr, ptr_nxt, win, off, idx;
    logic [2*NumReq-1:0]   rot;
    logic [NumReq-1:0]     idx_oh;
    logic                  any_req, grant, done;

    assign any_req = |req_valid_i;
    assign done    = (state == ACCESS) && pready_i;
    // Granting is gated by reset so req_ready_o reads zero while reset is held.
    assign grant   = !preset_i && any_req && ((state == IDLE) || done);

    // Rotate the request vector so the search always starts at bit 0 = requester ptr.
    always_comb begin
        int s;
        int s1;
        rot = {req_valid_i, req_valid_i} >> ptr;
        off = '0;
        for (int i = NumReq - 1; i >= 0; i--) begin
            if (rot[i]) off = IdxWidth'(i);
        end
        s = int'(ptr) + int'(off);
        if (s >= NumReq) s = s - NumReq;
        win = IdxWidth'(s);
        s1 = int'(win) + 1;
        if (s1 >= NumReq) s1 = 0;
        ptr_nxt = IdxWidth'(s1);
    end

    always_comb begin
        req_ready_o = '0;
        idx_oh      = '0;
        for (int k = 0; k < NumReq; k++) begin
            req_ready_o[k] = grant && (win == IdxWidth'(k));
            idx_oh[k]      = (idx == IdxWidth'(k));
        end
    end

    always_ff @(posedge pclk_i or posedge preset_i) begin
        if (preset_i) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        psel_o    = 1'b0;
        penable_o = 1'b0;
        case (state)
            IDLE: begin
                if (any_req) state_nxt = SETUP;
            end
            SETUP: begin
                psel_o    = 1'b1;
                state_nxt = ACCESS;
            end
            ACCESS: begin
                psel_o    = 1'b1;
                penable_o = 1'b1;
                if (pready_i) state_nxt = any_req ? SETUP : IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // idx still names the completing transfer on the done cycle, even if a new grant overwrites it.
    always_ff @(posedge pclk_i or posedge preset_i) begin
        if (preset_i) begin
            ptr         <= '0;
            idx         <= '0;
            paddr_o     <= '0;
            pwrite_o    <= 1'b0;
            pwdata_o    <= '0;
            rsp_valid_o <= '0;
            rsp_rdata_o <= '0;
            rsp_err_o   <= 1'b0;
        end else begin
            if (grant) begin
                ptr      <= ptr_nxt;
                idx      <= win;
                paddr_o  <= addr_arr[win];
                pwrite_o <= req_write_i[win];
                pwdata_o <= wdata_arr[win];
            end
            rsp_valid_o <= '0;
            if (done) begin
                rsp_valid_o <= idx_oh;
                rsp_rdata_o <= prdata_i;
                rsp_err_o   <= pslverr_i;
            end
        end
    end

endmodule

// File: tb/tb_apb_rr_master_arb.sv
// Bench for apb_rr_master_arb: transaction-level RR model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_apb_rr_master_arb;
    localparam int N  = 4;
    localparam int AW = 32;
    localparam int DW = 32;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [N-1:0]    req_valid = '0;
    logic [N-1:0]    req_write = '0;
    logic [N*AW-1:0] req_addr  = '0;
    logic [N*DW-1:0] req_wdata = '0;
    logic [N-1:0]    req_ready, rsp_valid;
    logic [DW-1:0]   rsp_rdata;
    logic            rsp_err;
    logic [AW-1:0]   paddr;
    logic            pwrite;
    logic [DW-1:0]   pwdata;
    logic            psel, penable;
    logic [DW-1:0]   prdata  = '0;
    logic            pready  = 1'b0;
    logic            pslverr = 1'b0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    apb_rr_master_arb #(.NumReq(N), .AddrWidth(AW), .DataWidth(DW)) dut (
        .pclk_i(clk), .preset_i(rst),
        .req_valid_i(req_valid), .req_ready_o(req_ready),
        .req_addr_i(req_addr), .req_write_i(req_write), .req_wdata_i(req_wdata),
        .rsp_valid_o(rsp_valid), .rsp_rdata_o(rsp_rdata), .rsp_err_o(rsp_err),
        .paddr_o(paddr), .pwrite_o(pwrite), .pwdata_o(pwdata),
        .psel_o(psel), .penable_o(penable),
        .prdata_i(prdata), .pready_i(pready), .pslverr_i(pslverr)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Bus model: phase 0 = no transfer, 1 = address phase, 2 = data phase.
    int            m_phase, m_ptr, m_idx, m_rsp_idx;
    logic [AW-1:0] m_addr;
    logic          m_write;
    logic [DW-1:0] m_wdata, m_rdata;
    logic          m_rsp, m_err;
    logic [N-1:0]  seen_ready = '0;

    always @(negedge clk) begin
        int           w;
        int           kk;
        logic         ok;
        logic [N-1:0] exp_rdy;
        logic [N-1:0] exp_rsp;
        if (rst) begin
            m_phase = 0; m_ptr = 0; m_idx = 0; m_rsp_idx = 0;
            m_addr = '0; m_write = 1'b0; m_wdata = '0;
            m_rdata = '0; m_rsp = 1'b0; m_err = 1'b0;
        end
        ok = !rst && (m_phase == 0 || (m_phase == 2 && pready));
        w = -1;
        for (int i = 0; i < N; i++) begin
            kk = (m_ptr + i) % N;
            if (w < 0 && req_valid[kk]) w = kk;
        end
        exp_rdy = '0;
        if (ok && w >= 0) exp_rdy[w] = 1'b1;
        exp_rsp = '0;
        if (m_rsp) exp_rsp[m_rsp_idx] = 1'b1;
        chk("model_ready",   req_ready, exp_rdy);
        chk("model_psel",    psel,      m_phase != 0);
        chk("model_penable", penable,   m_phase == 2);
        chk("model_paddr",   paddr,     m_addr);
        chk("model_pwrite",  pwrite,    m_write);
        chk("model_pwdata",  pwdata,    m_wdata);
        chk("model_rsp_vld", rsp_valid, exp_rsp);
        chk("model_rdata",   rsp_rdata, m_rdata);
        chk("model_err",     rsp_err,   m_err);
        seen_ready = req_ready;
        if (!rst) begin
            m_rsp = (m_phase == 2) && pready;
            if (m_rsp) begin
                m_rsp_idx = m_idx; m_rdata = prdata; m_err = pslverr;
            end
            if (m_phase == 0)      m_phase = (w >= 0) ? 1 : 0;
            else if (m_phase == 1) m_phase = 2;
            else if (pready)       m_phase = (w >= 0) ? 1 : 0;
            if (ok && w >= 0) begin
                m_idx   = w;
                m_addr  = req_addr[w*AW +: AW];
                m_write = req_write[w];
                m_wdata = req_wdata[w*DW +: DW];
                m_ptr   = (w + 1) % N;
            end
        end
    end

    initial begin
        logic [N-1:0] exp_oh;

        // Reset state
        @(negedge clk);
        chk("rst_psel", psel, 1'b0);
        chk("rst_rsp", rsp_valid, 4'b0000);
        chk("rst_paddr", paddr, 32'h0);
        step(); rst = 1'b0;

        // Req0 read, zero wait states
        step();
        req_valid[0] = 1'b1; req_write[0] = 1'b0; req_addr[0*AW +: AW] = 32'h0003_0004;
        @(negedge clk); chk("t1_ready", req_ready, 4'b0001);
        step(); req_valid[0] = 1'b0; pready = 1'b1; prdata = 32'h4;
        @(negedge clk); chk("t1_setup_psel", psel, 1'b1); chk("t1_setup_pen", penable, 1'b0);
        chk("t1_paddr", paddr, 32'h0003_0004);
        step();
        @(negedge clk); chk("t1_access_pen", penable, 1'b1);
        step();
        @(negedge clk); chk("t1_rsp", rsp_valid, 4'b0001); chk("t1_rdata", rsp_rdata, 32'h4);
        chk("t1_err", rsp_err, 1'b0); chk("t1_idle_psel", psel, 1'b0);

        // Req1 write with 3 wait states, req2 read with slave error queued behind it
        step();
        req_valid[1] = 1'b1; req_write[1] = 1'b1; req_addr[1*AW +: AW] = 32'h0003_0008;
        req_wdata[1*DW +: DW] = 32'hABC; pready = 1'b0;
        @(negedge clk); chk("t3_ready", req_ready, 4'b0010);
        step(); req_valid[1] = 1'b0;
        @(negedge clk); chk("t3_setup_pen", penable, 1'b0);
        step();
        req_valid[2] = 1'b1; req_write[2] = 1'b0; req_addr[2*AW +: AW] = 32'h0003_000C;
        for (int c = 0; c < 3; c++) begin
            if (c > 0) step();
            @(negedge clk);
            chk("t3_wait_pen", penable, 1'b1); chk("t3_wait_ready", req_ready, 4'b0000);
            chk("t3_wait_paddr", paddr, 32'h0003_0008); chk("t3_wait_pwdata", pwdata, 32'hABC);
            chk("t3_wait_pwrite", pwrite, 1'b1); chk("t3_wait_rsp", rsp_valid, 4'b0000);
        end
        step(); pready = 1'b1;
        @(negedge clk); chk("t3_last_pen", penable, 1'b1); chk("t4_ready", req_ready, 4'b0100);
        step(); req_valid[2] = 1'b0; pready = 1'b0;
        @(negedge clk); chk("t3_rsp", rsp_valid, 4'b0010); chk("t3_err", rsp_err, 1'b0);
        chk("t4_setup_pen", penable, 1'b0); chk("t4_paddr", paddr, 32'h0003_000C);
        step(); pready = 1'b1; pslverr = 1'b1; prdata = 32'h55;
        @(negedge clk); chk("t4_access_pen", penable, 1'b1);
        step(); pslverr = 1'b0;
        @(negedge clk); chk("t4_rsp", rsp_valid, 4'b0100); chk("t4_err", rsp_err, 1'b1);
        chk("t4_rdata", rsp_rdata, 32'h55); chk("t4_idle", psel, 1'b0);

        // Only req1 requesting, three back-to-back grants
        step();
        req_valid[1] = 1'b1; req_write[1] = 1'b0; req_addr[1*AW +: AW] = 32'h0003_0010;
        for (int g = 0; g < 3; g++) begin
            @(negedge clk); chk("t6_grant", req_ready, 4'b0010);
            step(); if (g == 2) req_valid[1] = 1'b0;
            @(negedge clk); chk("t6_setup_ready", req_ready, 4'b0000); chk("t6_psel", psel, 1'b1);
            if (g > 0) begin
                chk("t6_rsp", rsp_valid, 4'b0010); chk("t6_err", rsp_err, 1'b0);
            end
            step();
        end
        @(negedge clk); chk("t6_last_pen", penable, 1'b1);
        step();
        @(negedge clk); chk("t6_last_rsp", rsp_valid, 4'b0010);

        // All four requesting continuously from reset
        step(); rst = 1'b1; req_valid = 4'b1111;
        @(negedge clk); chk("t2_rst_ready", req_ready, 4'b0000); chk("t2_rst_psel", psel, 1'b0);
        step(); rst = 1'b0;
        @(negedge clk); chk("t2_grant0", req_ready, 4'b0001);
        for (int g = 1; g < 6; g++) begin
            step();
            @(negedge clk); chk("t2_setup_psel", psel, 1'b1); chk("t2_setup_pen", penable, 1'b0);
            chk("t2_setup_ready", req_ready, 4'b0000);
            step();
            exp_oh = '0; exp_oh[g % 4] = 1'b1;
            @(negedge clk); chk("t2_access_pen", penable, 1'b1); chk("t2_grant", req_ready, exp_oh);
        end
        step(); req_valid = 4'b0000;
        @(negedge clk); chk("t2_tail_psel", psel, 1'b1);
        step(); step();
        @(negedge clk); chk("t2_tail_rsp", rsp_valid, 4'b0010);

        // Reset during the data phase of req3
        step(); req_valid[3] = 1'b1; req_write[3] = 1'b0; req_addr[3*AW +: AW] = 32'h0003_0020;
        pready = 1'b0;
        @(negedge clk); chk("t5_grant3", req_ready, 4'b1000);
        step(); req_valid[3] = 1'b0;
        step();
        @(negedge clk); chk("t5_access_pen", penable, 1'b1);
        #2 rst = 1'b1;
        #1 chk("t5_async_psel", psel, 1'b0); chk("t5_async_pen", penable, 1'b0);
        step(); req_valid[3] = 1'b1; req_valid[1] = 1'b1; pready = 1'b1;
        @(negedge clk); chk("t5_no_rsp", rsp_valid, 4'b0000);
        step(); rst = 1'b0;
        @(negedge clk); chk("t5_ptr0_grant1", req_ready, 4'b0010); chk("t5_no_rsp2", rsp_valid, 4'b0000);

        // Randomized traffic; the model process does the checking
        for (int c = 0; c < 3000; c++) begin
            step();
            if (c == 1500) rst = 1'b1;
            if (c == 1503) rst = 1'b0;
            for (int k = 0; k < N; k++) begin
                if (req_valid[k] && seen_ready[k]) req_valid[k] = 1'b0;
                if (!req_valid[k] && $urandom_range(0, 2) == 0) begin
                    req_valid[k] = 1'b1;
                    req_write[k] = 1'($urandom_range(0, 1));
                    req_addr[k*AW +: AW]  = $urandom;
                    req_wdata[k*DW +: DW] = $urandom;
                end
            end
            pready  = ($urandom_range(0, 3) != 0);
            pslverr = ($urandom_range(0, 3) == 0);
            prdata  = $urandom;
        end
        step(); req_valid = '0; pready = 1'b1;
        for (int c = 0; c < 6; c++) step();
        @(negedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
